// File: rtl/mips_regfile_np.sv
// General-purpose register file for the 5-stage MIPS core: one clocked write port,
// NUM_RD read ports, reg0 hardwired to zero, optional bypass and registered reads.
module mips_regfile_np #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned READ_REG  = 0,
  parameter int unsigned PRESET_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       wr_ack
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              commit;
  logic              wr_ack_q;
  logic              wr_ack_d;

  function automatic logic [DATA_W-1:0] reset_val(input int unsigned idx);
    if (PRESET_EN != 0 && (idx == 1 || idx == 2)) begin
      return DATA_W'(idx);
    end
    return '0;
  endfunction

  always_comb begin
    commit   = we && (waddr != '0);
    wr_ack_d = commit;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (commit) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // Async reset forces the array regardless of any write requested during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= reset_val(i);
      end
      wr_ack_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_ack_q <= wr_ack_d;
    end
  end

  assign wr_ack = wr_ack_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdata_d;

    // Bypass is suppressed while rst is high so a dropped write never appears on a read.
    always_comb begin
      ra = raddr[g*ADDR_W +: ADDR_W];
      if (ra == '0) begin
        rdata_d = '0;
      end else if (BYPASS != 0 && commit && !rst && ra == waddr) begin
        rdata_d = wdata;
      end else begin
        rdata_d = regs_q[ra];
      end
    end

    if (READ_REG != 0) begin : g_reg
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end
      assign rdata[g*DATA_W +: DATA_W] = rdata_q;
    end else begin : g_comb
      assign rdata[g*DATA_W +: DATA_W] = rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_regfile_np.sv
// Scoreboard bench for mips_regfile_np: four parameter variants share one stimulus stream,
// expectations are queued by the stimulus and checked by a separate monitor.
module tb_mips_regfile_np;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic [63:0] rd [4];
  logic        ack [4];

  always #5 clk = ~clk;

  // 0: BYPASS=0 comb, 1: BYPASS=1 comb, 2: BYPASS=1 registered, 3: BYPASS=0 registered
  mips_regfile_np #(.BYPASS(0), .READ_REG(0)) u_c0 (.clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rd[0]), .wr_ack(ack[0]));
  mips_regfile_np #(.BYPASS(1), .READ_REG(0)) u_c1 (.clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rd[1]), .wr_ack(ack[1]));
  mips_regfile_np #(.BYPASS(1), .READ_REG(1)) u_r1 (.clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rd[2]), .wr_ack(ack[2]));
  mips_regfile_np #(.BYPASS(0), .READ_REG(1)) u_r0 (.clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rd[3]), .wr_ack(ack[3]));

  typedef struct {
    string       name;
    int          dut;
    int          port;   // 0/1 = rdata port, 2 = wr_ack
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] actual(input int dut, input int port);
    if (port == 2) return {31'd0, ack[dut]};
    return (port == 0) ? rd[dut][31:0] : rd[dut][63:32];
  endfunction

  initial begin : monitor
    exp_t e;
    logic [31:0] a;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = actual(e.dut, e.port);
        checks++;
        if (a !== e.exp) begin
          failures++;
          $display("FAIL %s dut%0d port%0d: got 0x%08h expected 0x%08h", e.name, e.dut, e.port, a, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int dut, input int port, input logic [31:0] exp);
    q.push_back('{name, dut, port, exp});
  endtask

  task automatic sample();
    -> sample_ev;
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; raddr = {ra1, ra0};
    #2;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b1;
    raddr = {5'd2, 5'd1};
    #2;
    expect_val("rst_preset1", 0, 0, 32'd1);
    expect_val("rst_preset2", 0, 1, 32'd2);
    expect_val("rst_preset1_byp", 1, 0, 32'd1);
    expect_val("rst_regread0", 2, 0, 32'd0);
    expect_val("rst_regread1", 3, 1, 32'd0);
    expect_val("rst_ack", 0, 2, 32'd0);
    sample();
    raddr = {5'd2, 5'd5};
    #1;
    expect_val("rst_reg5", 0, 0, 32'd0);
    sample();

    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
    rst = 1'b0;
    after_edge();
    expect_val("rr_preset1", 2, 0, 32'd1);
    expect_val("rr_preset2", 2, 1, 32'd2);
    sample();

    // Basic write/read
    drive(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7);
    expect_val("wr_pre_nobyp", 0, 0, 32'd0);
    expect_val("wr_pre_byp", 1, 0, 32'hDEADBEEF);
    sample();
    after_edge();
    expect_val("wr_post", 0, 0, 32'hDEADBEEF);
    expect_val("wr_ack1", 0, 2, 32'd1);
    expect_val("wr_ack1_rr", 3, 2, 32'd1);
    expect_val("rr_byp_new", 2, 0, 32'hDEADBEEF);
    expect_val("rr_nobyp_old", 3, 0, 32'd0);
    sample();
    drive(1'b0, 5'd7, 32'd0, 5'd7, 5'd7);
    expect_val("wr_hold", 0, 0, 32'hDEADBEEF);
    sample();
    after_edge();
    expect_val("wr_ack0", 0, 2, 32'd0);
    expect_val("rr_nobyp_late", 3, 0, 32'hDEADBEEF);
    sample();

    // Bypass on both ports
    drive(1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3);
    expect_val("byp_p0", 1, 0, 32'h12345678);
    expect_val("byp_p1", 1, 1, 32'h12345678);
    expect_val("nobyp_p0", 0, 0, 32'd0);
    sample();
    after_edge();
    expect_val("byp_post", 0, 0, 32'h12345678);
    expect_val("rr_byp_p0", 2, 0, 32'h12345678);
    expect_val("rr_byp_p1", 2, 1, 32'h12345678);
    expect_val("rr_nobyp_p1", 3, 1, 32'd0);
    sample();
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    expect_val("byp_stored", 1, 0, 32'h12345678);
    sample();

    // Reg0 protection
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    expect_val("r0_pre_byp", 1, 0, 32'd0);
    sample();
    after_edge();
    expect_val("r0_post", 1, 0, 32'd0);
    expect_val("r0_rr", 2, 0, 32'd0);
    expect_val("r0_noack", 1, 2, 32'd0);
    sample();

    // Registered read with same-cycle write
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd2);
    after_edge();
    expect_val("rr9_byp", 2, 0, 32'hA5A5A5A5);
    expect_val("rr9_nobyp", 3, 0, 32'd0);
    expect_val("rr9_p1", 2, 1, 32'd2);
    sample();
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd2);
    after_edge();
    expect_val("rr9_nobyp_late", 3, 0, 32'hA5A5A5A5);
    sample();

    // Top address
    drive(1'b1, 5'd31, 32'h80000000, 5'd31, 5'd9);
    after_edge();
    expect_val("top_addr", 0, 0, 32'h80000000);
    expect_val("top_p1", 0, 1, 32'hA5A5A5A5);
    sample();

    // Async reset mid-operation
    drive(1'b1, 5'd4, 32'h55, 5'd4, 5'd4);
    after_edge();
    expect_val("r4_55", 0, 0, 32'h55);
    expect_val("r4_55_rr", 2, 0, 32'h55);
    sample();
    drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd1);
    after_edge();
    expect_val("r4_55_rr0", 3, 0, 32'h55);
    sample();
    drive(1'b1, 5'd4, 32'h77, 5'd4, 5'd1);
    rst = 1'b1;
    #1;
    expect_val("arst_c0", 0, 0, 32'd0);
    expect_val("arst_c1_nobyp", 1, 0, 32'd0);
    expect_val("arst_rr1", 2, 0, 32'd0);
    expect_val("arst_rr0", 3, 0, 32'd0);
    expect_val("arst_ack", 0, 2, 32'd0);
    sample();
    after_edge();
    expect_val("arst_dropped", 0, 0, 32'd0);
    expect_val("arst_ack_hold", 0, 2, 32'd0);
    sample();
    drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd1);
    rst = 1'b0;
    #1;
    expect_val("rel_r4", 0, 0, 32'd0);
    expect_val("rel_preset1", 0, 1, 32'd1);
    sample();
    drive(1'b1, 5'd4, 32'h66, 5'd4, 5'd1);
    after_edge();
    expect_val("rel_r4_66", 0, 0, 32'h66);
    expect_val("rel_ack", 0, 2, 32'd1);
    expect_val("rel_rr_66", 2, 0, 32'h66);
    sample();
    drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd1);

    #5;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mips_regfile_np.md
Name: mips_regfile_np

Overview:
- Parametrised general-purpose register file for the 5-stage pipelined MIPS core; next generation of the combinational register array.
- Clocked write port, NUM_RD independent read ports, register 0 hardwired to zero.
- Optional write-to-read bypass, so ID reads in the same cycle as the WB write.
- Optional registered read mode for the deeper-pipelined variant.

Parameters:
DATA_W  32  register width in bits
ADDR_W  5  address width; depth = 2**ADDR_W
NUM_RD  2  number of read ports (1..4)
BYPASS  1  1 = same-cycle write data forwarded to matching reads; 0 = read returns the old value
READ_REG  0  0 = combinational read; 1 = read data registered, 1-cycle latency
PRESET_EN  1  1 = reset loads reg1=1, reg2=2; 0 = reset clears all registers

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  asynchronous, active-high reset
we  in  1  write enable, sampled at rising clk
waddr  in  ADDR_W  write register index
wdata  in  DATA_W  write data
raddr  in  NUM_RD*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
wr_ack  out  1  pulses high for one cycle after a committed write to a nonzero register

Behaviour:
- One clock (clk). Reset (rst) is asynchronous and active-high.
- Reset, asserted asynchronously:
  - All registers are cleared to 0.
  - If PRESET_EN=1, reg1=1 and reg2=2 (zero-extended to DATA_W).
  - wr_ack=0.
  - If READ_REG=1, the rdata register is 0.
  - If READ_REG=0, rdata reflects the post-reset contents immediately.
- Reset release: normal operation begins at the first rising clk with rst low. A write requested in a cycle where rst is high is dropped.
- Write:
  - When we=1 and waddr!=0, wdata is stored at the rising edge.
  - Writes to waddr=0 are ignored; reg0 always reads 0.
  - wr_ack=1 in the cycle after a committed write, else 0. Writes to reg0 produce no ack.
- Read, READ_REG=0:
  - rdata[i] is combinational from raddr[i].
  - raddr[i]=0 returns 0.
  - If BYPASS=1, we=1 and raddr[i]==waddr!=0, rdata[i]=wdata in the same cycle, before the edge.
  - If BYPASS=0, rdata[i] returns the stored value and updates after the edge.
- Read, READ_REG=1:
  - rdata[i] is captured at the rising edge from raddr[i] presented in the prior cycle.
  - Latency is 1 cycle.
  - If BYPASS=1 and a write to the same nonzero address commits on that edge, the captured value is the new wdata.
  - If BYPASS=0, the captured value is the pre-write value.
- Multiple read ports addressing the same register all return identical data, including under bypass.
- Width rules:
  - Addresses are unsigned and use all 2**ADDR_W entries; no out-of-range condition exists.
  - Data is stored exactly DATA_W bits, with no sign handling.
- X-safety: reads of never-written, non-preset registers return 0 (guaranteed by reset).
- Reset mid-operation: a pending write is lost and rdata is forced per the reset rules. The next write after release behaves normally.
- Implementation:
  - Storage is a flop array with an async reset; no inferred RAM, because of the reset requirement.
  - Read muxes and bypass compare are generated per port.

Test Plan:
1. Reset, defaults, PRESET_EN=1: assert rst, raddr0=1, raddr1=2 -> rdata0=0x00000001, rdata1=0x00000002. raddr0=5 -> 0; wr_ack=0.
2. Basic write/read, READ_REG=0, BYPASS=0: we=1, waddr=7, wdata=0xDEADBEEF, raddr0=7 -> rdata0 shows the old 0 before the edge and 0xDEADBEEF after. wr_ack=1 for exactly one cycle after the edge.
3. Bypass, BYPASS=1: same cycle as we=1, waddr=3, wdata=0x12345678, raddr0=raddr1=3 -> both rdata=0x12345678 before the edge. A next-cycle read of reg3 returns 0x12345678.
4. Reg0 protection: we=1, waddr=0, wdata=0xFFFFFFFF, raddr0=0 with BYPASS=1 -> rdata0=0 before and after the edge; wr_ack stays 0.
5. Registered read, READ_REG=1, BYPASS=1:
   - Cycle N: raddr0=9, we=1, waddr=9, wdata=0xA5A5A5A5 -> rdata0=0xA5A5A5A5 after edge N.
   - With BYPASS=0 the same stimulus -> rdata0 equals the old value (0), and 0xA5A5A5A5 one cycle later.
6. Async reset mid-operation: write 0x55 to reg4, assert rst between edges -> rdata immediately 0 for reg4 (and for the registered port). A write issued while rst is high is not stored. After release, a write of 0x66 to reg4 reads 0x66.
